// File: rtl/mem_pipe_ctrl.sv
// Byte-strobed single-port memory with an RD_LAT-stage read pipeline and an in-order response FIFO.
// Read data is visible RD_LAT cycles after accept; ready drops once RSP_DEPTH reads are unpopped.
module mem_pipe_ctrl #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 8,
   parameter int DEPTH     = 256,
   parameter int RD_LAT    = 2,
   parameter int RSP_DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           res,
   input  logic                           valid,
   output logic                           ready,
   input  logic                           wr_rd,
   input  logic [ADDR_W-1:0]              addr,
   input  logic [DATA_W-1:0]              wdata,
   input  logic [DATA_W/8-1:0]            wstrb,
   output logic                           rvalid,
   input  logic                           rready,
   output logic [DATA_W-1:0]              rdata,
   output logic                           rerr,
   output logic                           wr_err,
   output logic [$clog2(RSP_DEPTH+1)-1:0] outstanding
);

   localparam int NB    = DATA_W / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(RSP_DEPTH + 1);
   localparam int PTR_W = $clog2(RSP_DEPTH);

   localparam logic [CNT_W-1:0]  CRED_MAX = CNT_W'(RSP_DEPTH);
   localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(RSP_DEPTH - 1);
   localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic              ready_q, ready_d;
   logic [CNT_W-1:0]  outstanding_q, outstanding_d;
   logic              wr_err_q, wr_err_d;

   logic              pipe_vld_q [RD_LAT];
   logic [DATA_W-1:0] pipe_dat_q [RD_LAT];
   logic              pipe_err_q [RD_LAT];

   logic [DATA_W-1:0] fifo_dat_q [RSP_DEPTH];
   logic              fifo_err_q [RSP_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;

   logic              acc_wr, acc_rd;
   logic              in_range;
   logic [IDX_W-1:0]  idx;
   logic [DATA_W-1:0] rd_word;
   logic              push, pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   assign acc_wr   = valid && ready_q && wr_rd;
   assign acc_rd   = valid && ready_q && !wr_rd;
   assign in_range = {1'b0, addr} < DEPTH_X;
   assign idx      = addr[IDX_W-1:0];
   assign rd_word  = in_range ? mem_q[idx] : '0;

   // The FIFO never overflows: outstanding credits cover both pipeline and queue.
   assign push = pipe_vld_q[RD_LAT-1];
   assign pop  = rvalid && rready;

   always_comb begin
      outstanding_d = outstanding_q;
      case ({acc_rd, pop})
         2'b10:   outstanding_d = outstanding_q + 1'b1;
         2'b01:   outstanding_d = outstanding_q - 1'b1;
         default: outstanding_d = outstanding_q;
      endcase
      ready_d  = outstanding_d < CRED_MAX;
      wr_err_d = wr_err_q || (acc_wr && !in_range);

      fifo_cnt_d = fifo_cnt_q;
      case ({push, pop})
         2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
         2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
         default: fifo_cnt_d = fifo_cnt_q;
      endcase
      wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         ready_q       <= 1'b0;
         outstanding_q <= '0;
         wr_err_q      <= 1'b0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         fifo_cnt_q    <= '0;
         for (int i = 0; i < RD_LAT; i++) pipe_vld_q[i] <= 1'b0;
      end else begin
         ready_q       <= ready_d;
         outstanding_q <= outstanding_d;
         wr_err_q      <= wr_err_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         fifo_cnt_q    <= fifo_cnt_d;
         pipe_vld_q[0] <= acc_rd;
         for (int i = 1; i < RD_LAT; i++) pipe_vld_q[i] <= pipe_vld_q[i-1];
      end
   end

   // Array, pipeline payload and FIFO storage are qualified by the valid/count state above.
   always_ff @(posedge clk) begin
      if (acc_wr && in_range) begin
         for (int b = 0; b < NB; b++) begin
            if (wstrb[b]) mem_q[idx][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
      if (acc_rd) begin
         pipe_dat_q[0] <= rd_word;
         pipe_err_q[0] <= !in_range;
      end
      for (int i = 1; i < RD_LAT; i++) begin
         pipe_dat_q[i] <= pipe_dat_q[i-1];
         pipe_err_q[i] <= pipe_err_q[i-1];
      end
      if (push) begin
         fifo_dat_q[wr_ptr_q] <= pipe_dat_q[RD_LAT-1];
         fifo_err_q[wr_ptr_q] <= pipe_err_q[RD_LAT-1];
      end
   end

   assign ready       = ready_q;
   assign rvalid      = fifo_cnt_q != '0;
   assign rdata       = rvalid ? fifo_dat_q[rd_ptr_q] : '0;
   assign rerr        = rvalid && fifo_err_q[rd_ptr_q];
   assign wr_err      = wr_err_q;
   assign outstanding = outstanding_q;

endmodule

// File: tb/tb_mem_pipe_ctrl.sv
// Directed + random bench for mem_pipe_ctrl with a response scoreboard (DEPTH=200, RD_LAT=2, RSP_DEPTH=4).
module tb_mem_pipe_ctrl;
   localparam int DW  = 32;
   localparam int AW  = 8;
   localparam int DEP = 200;
   localparam int LAT = 2;
   localparam int RSD = 4;

   logic          clk = 1'b0;
   logic          res;
   logic          valid, ready, wr_rd, rvalid, rready, rerr, wr_err;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata, rdata;
   logic [3:0]    wstrb;
   logic [2:0]    outstanding;

   always #5 clk = ~clk;

   mem_pipe_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .RD_LAT(LAT), .RSP_DEPTH(RSD)) dut (
      .clk(clk), .res(res), .valid(valid), .ready(ready), .wr_rd(wr_rd), .addr(addr),
      .wdata(wdata), .wstrb(wstrb), .rvalid(rvalid), .rready(rready), .rdata(rdata),
      .rerr(rerr), .wr_err(wr_err), .outstanding(outstanding)
   );

   typedef struct packed {
      logic        err;
      logic [31:0] dat;
      logic        lat;
      logic [31:0] acc;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mdl [256];
   logic [31:0] cyc = 0;
   logic        lat_on = 1'b0;
   int          tests = 0;
   int          fails = 0;
   int          n_pop = 0;
   int          n_rd = 0;
   logic [7:0]  picks [8] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd5, 8'd50, 8'd199, 8'd210};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void push_rd(input logic [7:0] a);
      exp_t e;
      e.err = (a >= DEP);
      e.dat = (a >= DEP) ? 32'h0 : mdl[a];
      e.lat = lat_on;
      e.acc = cyc + 1;
      sb.push_back(e);
   endfunction

   // Response monitor: sampled on the falling edge, a pop happens at the next rising edge.
   always @(negedge clk) begin
      exp_t e;
      if (res === 1'b1) begin
         check("outstanding_max", 64'(outstanding <= 3'd4), 64'd1);
         if (rvalid !== 1'b1) begin
            check("rdata_idle", rdata, 0);
         end else if (rready === 1'b1) begin
            if (sb.size() == 0) begin
               check("unexpected_rsp", rvalid, 0);
            end else begin
               e = sb.pop_front();
               n_pop++;
               check("rsp", {rerr, rdata}, {e.err, e.dat});
               if (e.lat) check("rsp_latency", cyc - e.acc, LAT);
            end
         end
      end
   end

   // Called at posedge+1 with request inputs driven; returns at posedge+1 after acceptance.
   task automatic wait_acc(output logic [31:0] acc_cyc);
      int n = 0;
      @(negedge clk);
      while (ready !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("req_accept", ready, 1);
      acc_cyc = cyc + 1;
      if (ready === 1'b1) begin
         if (wr_rd) begin
            if (addr < DEP)
               for (int b = 0; b < 4; b++)
                  if (wstrb[b]) mdl[addr][b*8 +: 8] = wdata[b*8 +: 8];
         end else begin
            push_rd(addr);
         end
      end
      @(posedge clk); #1;
      valid = 1'b0;
   endtask

   task automatic req(input logic w, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] ac;
      valid = 1'b1; wr_rd = w; addr = a; wdata = d; wstrb = s;
      wait_acc(ac);
   endtask

   task automatic drain();
      int n = 0;
      rready = 1'b1;
      while (sb.size() != 0 && n < 60) begin
         @(posedge clk);
         n++;
      end
      @(posedge clk); #1;
      check("drain_empty", sb.size(), 0);
      @(negedge clk);
      check("drain_outstanding", outstanding, 0);
      @(posedge clk); #1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not complete, tests %0d", tests);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] k, ac;
      logic        took;
      res = 1'b1; valid = 1'b0; wr_rd = 1'b0; addr = '0; wdata = '0; wstrb = '0; rready = 1'b0;
      #1 res = 1'b0;
      #3;
      check("rst_ready", ready, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_rdata", rdata, 0);
      check("rst_rerr", rerr, 0);
      check("rst_wr_err", wr_err, 0);
      check("rst_outstanding", outstanding, 0);
      repeat (2) @(posedge clk);
      #1 res = 1'b1;
      @(negedge clk);
      check("ready_before_edge", ready, 0);
      @(posedge clk); #1;
      check("ready_after_edge", ready, 1);

      // Back-to-back writes then reads with latency tracking
      for (int a = 0; a < 4; a++) req(1'b1, 8'(a), 32'h11111111 * (a + 1), 4'hF);
      rready = 1'b1;
      lat_on = 1'b1;
      for (int a = 0; a < 4; a++) req(1'b0, 8'(a), 32'h0, 4'h0);
      drain();
      lat_on = 1'b0;

      // Byte strobes, zero strobe
      req(1'b1, 8'd5, 32'hAABBCCDD, 4'hF);
      req(1'b1, 8'd5, 32'h00000011, 4'b0001);
      req(1'b0, 8'd5, 32'h0, 4'h0);
      req(1'b1, 8'd5, 32'hFFFFFFFF, 4'h0);
      req(1'b0, 8'd5, 32'h0, 4'h0);
      drain();

      // Credit backpressure with rready held low
      rready = 1'b0;
      for (int a = 0; a < 4; a++) req(1'b0, 8'(a), 32'h0, 4'h0);
      valid = 1'b1; wr_rd = 1'b0; addr = 8'd5;
      @(negedge clk);
      check("bp_ready", ready, 0);
      check("bp_outstanding", outstanding, 4);
      repeat (2) @(negedge clk);
      check("bp_rvalid", rvalid, 1);
      check("bp_still_4", outstanding, 4);
      @(posedge clk); #1;
      rready = 1'b1;
      k = cyc;
      @(posedge clk); #1;
      rready = 1'b0;
      wait_acc(ac);
      check("bp_accept_after_pop", ac, k + 2);
      valid = 1'b1; wr_rd = 1'b0; addr = 8'd2;
      @(negedge clk);
      check("bp_ready_again", ready, 0);
      check("bp_outstanding_again", outstanding, 4);
      @(posedge clk); #1;
      rready = 1'b1;
      wait_acc(ac);
      drain();

      // Out-of-range handling
      req(1'b1, 8'd50, 32'h50505050, 4'hF);
      req(1'b1, 8'd199, 32'h19919919, 4'hF);
      check("wr_err_clear", wr_err, 0);
      req(1'b1, 8'd250, 32'hDEADBEEF, 4'hF);
      check("wr_err_set", wr_err, 1);
      req(1'b0, 8'd210, 32'h0, 4'h0);
      req(1'b0, 8'd200, 32'h0, 4'h0);
      req(1'b0, 8'd199, 32'h0, 4'h0);
      req(1'b0, 8'd50, 32'h0, 4'h0);
      drain();
      check("wr_err_held", wr_err, 1);

      // Reset with reads queued and in flight
      rready = 1'b0;
      req(1'b0, 8'd1, 32'h0, 4'h0);
      repeat (2) @(posedge clk);
      #1;
      check("mid_rvalid_queued", rvalid, 1);
      req(1'b0, 8'd2, 32'h0, 4'h0);
      req(1'b0, 8'd3, 32'h0, 4'h0);
      req(1'b0, 8'd0, 32'h0, 4'h0);
      res = 1'b0;
      #1;
      check("arst_rvalid", rvalid, 0);
      check("arst_ready", ready, 0);
      check("arst_outstanding", outstanding, 0);
      check("arst_rdata", rdata, 0);
      check("arst_wr_err", wr_err, 0);
      sb.delete();
      repeat (2) @(posedge clk);
      #1 res = 1'b1;
      rready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("post_rst_no_rsp", rvalid, 0);
      req(1'b0, 8'd0, 32'h0, 4'h0);
      drain();

      // Random valid, rready high, then random rready
      n_pop = 0;
      n_rd = 0;
      wr_rd = 1'b0;
      rready = 1'b1;
      for (int c = 0; c < 1400; c++) begin
         if (!valid) begin
            valid = 1'($urandom_range(0, 1));
            addr  = picks[$urandom_range(0, 7)];
         end
         if (c >= 1000) rready = 1'($urandom_range(0, 1));
         @(negedge clk);
         took = valid && ready;
         if (took) begin
            push_rd(addr);
            n_rd++;
         end
         @(posedge clk); #1;
         if (took) valid = 1'b0;
      end
      valid = 1'b0;
      drain();
      check("rand_pop_count", n_pop, n_rd);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
